// File: rtl/tcp_listen_port_ctrl.sv
// Listen-port manager: after a start delay, opens NUM_PORTS consecutive server ports one at a time.
// A port that gets a failure status or no answer is retried after a back-off, up to MAX_RETRIES times.
module tcp_listen_port_ctrl #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter logic [15:0] BASE_PORT      = 16'h0B48,
    parameter int unsigned PORT_STRIDE    = 1,
    parameter int unsigned START_DELAY    = 32768,
    parameter int unsigned STATUS_TIMEOUT = 65535,
    parameter int unsigned RETRY_INTERVAL = 16384,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic                 m_axis_listen_port_TVALID,
    input  logic                 m_axis_listen_port_TREADY,
    output logic [15:0]          m_axis_listen_port_TDATA,
    input  logic                 s_axis_listen_port_status_TVALID,
    output logic                 s_axis_listen_port_status_TREADY,
    input  logic [7:0]           s_axis_listen_port_status_TDATA,
    input  logic                 restart,
    output logic [NUM_PORTS-1:0] ports_open,
    output logic [NUM_PORTS-1:0] ports_failed,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned MAX_AB = (START_DELAY > STATUS_TIMEOUT) ? START_DELAY : STATUS_TIMEOUT;
    localparam int unsigned MAX_T  = (MAX_AB > RETRY_INTERVAL) ? MAX_AB : RETRY_INTERVAL;
    localparam int unsigned CW     = $clog2(MAX_T + 2);
    localparam int unsigned IW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    // Wait-state exit thresholds: BACKOFF and WAIT_STATUS last exactly N cycles,
    // WAIT_START compares against the full delay so the first request lands one cycle later.
    localparam logic [CW-1:0] SD_LAST = CW'(START_DELAY);
    localparam logic [CW-1:0] TO_LAST = (STATUS_TIMEOUT == 0) ? '0 : CW'(STATUS_TIMEOUT - 1);
    localparam logic [CW-1:0] RI_LAST = (RETRY_INTERVAL == 0) ? '0 : CW'(RETRY_INTERVAL - 1);
    localparam logic [RW-1:0] RC_MAX  = RW'(MAX_RETRIES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_START,
        ST_SEND,
        ST_WAIT_STATUS,
        ST_BACKOFF,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [RW-1:0]          rc_q, rc_d;
    logic [NUM_PORTS-1:0]   open_q, open_d;
    logic [NUM_PORTS-1:0]   fail_q, fail_d;

    logic [CW-1:0]          cnt_inc;
    logic [15:0]            port_num;
    logic                   status_ok;
    logic                   attempt_failed;
    logic                   unused_status_bits;

    // Multiplication and addition modulo 2^16 give the wrapped port number directly.
    assign port_num           = BASE_PORT + 16'(32'(idx_q) * PORT_STRIDE);
    assign status_ok          = s_axis_listen_port_status_TDATA[0];
    assign unused_status_bits = ^s_axis_listen_port_status_TDATA[7:1];
    assign cnt_inc            = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_WAIT_START;
            cnt_q   <= '0;
            idx_q   <= '0;
            rc_q    <= '0;
            open_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rc_q    <= rc_d;
            open_q  <= open_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        rc_d           = rc_q;
        open_d         = open_q;
        fail_d         = fail_q;
        attempt_failed = 1'b0;

        unique case (state_q)
            ST_WAIT_START: begin
                cnt_d = cnt_inc;
                if (cnt_q >= SD_LAST) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (m_axis_listen_port_TREADY) begin
                    state_d = ST_WAIT_STATUS;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_STATUS: begin
                cnt_d = cnt_inc;
                // A beat in the timeout cycle takes priority over the timeout.
                if (s_axis_listen_port_status_TVALID) begin
                    if (status_ok) begin
                        open_d[idx_q] = 1'b1;
                        state_d       = ST_NEXT;
                    end else begin
                        attempt_failed = 1'b1;
                    end
                end else if (cnt_q >= TO_LAST) begin
                    attempt_failed = 1'b1;
                end
                if (attempt_failed) begin
                    cnt_d = '0;
                    if (rc_q < RC_MAX) begin
                        rc_d    = rc_q + RW'(1);
                        state_d = ST_BACKOFF;
                    end else begin
                        fail_d[idx_q] = 1'b1;
                        state_d       = ST_NEXT;
                    end
                end
            end
            ST_BACKOFF: begin
                cnt_d = cnt_inc;
                if (cnt_q >= RI_LAST) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
            ST_NEXT: begin
                rc_d = '0;
                if (idx_q == IDX_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    open_d  = '0;
                    fail_d  = '0;
                    idx_d   = '0;
                    rc_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_WAIT_START;
                cnt_d   = '0;
            end
        endcase
    end

    assign m_axis_listen_port_TVALID        = (state_q == ST_SEND);
    assign m_axis_listen_port_TDATA         = (state_q == ST_SEND) ? port_num : '0;
    assign s_axis_listen_port_status_TREADY = 1'b1;
    assign ports_open                       = open_q;
    assign ports_failed                     = fail_q;
    assign done                             = (state_q == ST_DONE);
    assign busy                             = (state_q != ST_DONE);

endmodule

// File: tb/tb_tcp_listen_port_ctrl.sv
// Directed bench for tcp_listen_port_ctrl: three instances cover retries, timeouts and port wrap.
module tb_tcp_listen_port_ctrl;

    localparam int SD = 20;
    localparam int TO = 100;
    localparam int RI = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn    [3];
    logic        tready  [3];
    logic        svalid  [3];
    logic        restart [3];
    logic [7:0]  sdata   [3];
    logic        tvalid  [3];
    logic        stready [3];
    logic        busy    [3];
    logic        done    [3];
    logic [15:0] tdata   [3];
    logic [3:0]  popen0, pfail0, popen1, pfail1;
    logic [1:0]  popen2, pfail2;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          hs_cnt   [3];
    logic [15:0] hs_data  [3][32];

    tcp_listen_port_ctrl #(
        .NUM_PORTS(4), .BASE_PORT(16'h0B48), .PORT_STRIDE(1), .START_DELAY(SD),
        .STATUS_TIMEOUT(TO), .RETRY_INTERVAL(RI), .MAX_RETRIES(3)
    ) u_dut0 (
        .aclk(clk), .aresetn(rstn[0]),
        .m_axis_listen_port_TVALID(tvalid[0]), .m_axis_listen_port_TREADY(tready[0]),
        .m_axis_listen_port_TDATA(tdata[0]),
        .s_axis_listen_port_status_TVALID(svalid[0]), .s_axis_listen_port_status_TREADY(stready[0]),
        .s_axis_listen_port_status_TDATA(sdata[0]),
        .restart(restart[0]), .ports_open(popen0), .ports_failed(pfail0),
        .busy(busy[0]), .done(done[0])
    );

    tcp_listen_port_ctrl #(
        .NUM_PORTS(4), .BASE_PORT(16'h0B48), .PORT_STRIDE(1), .START_DELAY(SD),
        .STATUS_TIMEOUT(TO), .RETRY_INTERVAL(RI), .MAX_RETRIES(1)
    ) u_dut1 (
        .aclk(clk), .aresetn(rstn[1]),
        .m_axis_listen_port_TVALID(tvalid[1]), .m_axis_listen_port_TREADY(tready[1]),
        .m_axis_listen_port_TDATA(tdata[1]),
        .s_axis_listen_port_status_TVALID(svalid[1]), .s_axis_listen_port_status_TREADY(stready[1]),
        .s_axis_listen_port_status_TDATA(sdata[1]),
        .restart(restart[1]), .ports_open(popen1), .ports_failed(pfail1),
        .busy(busy[1]), .done(done[1])
    );

    tcp_listen_port_ctrl #(
        .NUM_PORTS(2), .BASE_PORT(16'hFFFF), .PORT_STRIDE(1), .START_DELAY(SD),
        .STATUS_TIMEOUT(TO), .RETRY_INTERVAL(RI), .MAX_RETRIES(3)
    ) u_dut2 (
        .aclk(clk), .aresetn(rstn[2]),
        .m_axis_listen_port_TVALID(tvalid[2]), .m_axis_listen_port_TREADY(tready[2]),
        .m_axis_listen_port_TDATA(tdata[2]),
        .s_axis_listen_port_status_TVALID(svalid[2]), .s_axis_listen_port_status_TREADY(stready[2]),
        .s_axis_listen_port_status_TDATA(sdata[2]),
        .restart(restart[2]), .ports_open(popen2), .ports_failed(pfail2),
        .busy(busy[2]), .done(done[2])
    );

    // Handshake log, sampled just before each rising edge.
    always @(negedge clk) begin
        #4;
        for (int d = 0; d < 3; d++) begin
            if (rstn[d] && tvalid[d] && tready[d]) begin
                if (hs_cnt[d] < 32) hs_data[d][hs_cnt[d]] = tdata[d];
                hs_cnt[d] = hs_cnt[d] + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for a request, accept it, answer after lat cycles; returns one cycle after the beat edge.
    task automatic serve(input int d, input bit ok, input int lat);
        int n = 0;
        while (!tvalid[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tvalid[d] !== 1'b1) begin
            n_fails++;
            $display("FAIL serve_req_dut%0d: got tvalid=%b, expected 1 within 400 cycles", d, tvalid[d]);
        end else begin
            tready[d] = 1'b1;
            @(negedge clk);
            repeat (lat - 1) @(negedge clk);
            sdata[d]  = ok ? 8'h01 : 8'hFE;
            svalid[d] = 1'b1;
            @(negedge clk);
            svalid[d] = 1'b0;
            sdata[d]  = 8'h00;
        end
    endtask

    task automatic test_reset;
        int n = 0;
        tready[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tvalid[0], tdata[0], popen0, pfail0, busy[0], done[0], stready[0]} !==
            {1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL reset_values: got v=%b d=%h o=%h f=%h b=%b dn=%b sr=%b, expected 0 0000 0 0 1 0 1",
                     tvalid[0], tdata[0], popen0, pfail0, busy[0], done[0], stready[0]);
        end
        rstn[0] = 1'b1;
        while (!tvalid[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== SD + 1) begin
            n_fails++;
            $display("FAIL start_delay: got %0d cycles, expected %0d", n, SD + 1);
        end
        n_checks++;
        if (tdata[0] !== 16'h0B48) begin
            n_fails++;
            $display("FAIL first_port: got %h, expected 0b48", tdata[0]);
        end
    endtask

    task automatic test_backpressure;
        hs_cnt[0] = 0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({tvalid[0], tdata[0]} !== {1'b1, 16'h0B48}) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h, expected v=1 d=0b48", i, tvalid[0], tdata[0]);
            end
            @(negedge clk);
        end
        tready[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tvalid[0], 32'(hs_cnt[0])} !== {1'b0, 32'd1}) begin
            n_fails++;
            $display("FAIL single_handshake: got v=%b hs=%0d, expected v=0 hs=1", tvalid[0], hs_cnt[0]);
        end
        repeat (4) @(negedge clk);
        sdata[0]  = 8'h01;
        svalid[0] = 1'b1;
        @(negedge clk);
        svalid[0] = 1'b0;
        sdata[0]  = 8'h00;
        n_checks++;
        if ({popen0, tvalid[0]} !== {4'b0001, 1'b0}) begin
            n_fails++;
            $display("FAIL open_port0: got o=%b v=%b, expected o=0001 v=0", popen0, tvalid[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({tvalid[0], tdata[0]} !== {1'b1, 16'h0B49}) begin
            n_fails++;
            $display("FAIL next_request: got v=%b d=%h, expected v=1 d=0b49", tvalid[0], tdata[0]);
        end
    endtask

    task automatic test_main;
        for (int p = 1; p < 4; p++) serve(0, 1'b1, 5);
        n_checks++;
        if ({done[0], busy[0]} !== 2'b01) begin
            n_fails++;
            $display("FAIL done_in_next: got done=%b busy=%b, expected 0 1", done[0], busy[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({done[0], busy[0]} !== 2'b10) begin
            n_fails++;
            $display("FAIL done_rise: got done=%b busy=%b, expected 1 0", done[0], busy[0]);
        end
        n_checks++;
        if (hs_cnt[0] !== 4) begin
            n_fails++;
            $display("FAIL main_hs_count: got %0d, expected 4", hs_cnt[0]);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (hs_data[0][j] !== 16'h0B48 + 16'(j)) begin
                n_fails++;
                $display("FAIL main_tdata[%0d]: got %h, expected %h", j, hs_data[0][j], 16'h0B48 + 16'(j));
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if ({popen0, pfail0, done[0]} !== {4'hF, 4'h0, 1'b1}) begin
            n_fails++;
            $display("FAIL main_masks: got o=%h f=%h done=%b, expected f 0 1", popen0, pfail0, done[0]);
        end
    endtask

    task automatic test_restart_retry;
        int n;
        int cnt49 = 0;
        hs_cnt[0]  = 0;
        restart[0] = 1'b1;
        @(negedge clk);
        restart[0] = 1'b0;
        n_checks++;
        if ({popen0, pfail0, tvalid[0], tdata[0], busy[0]} !== {4'h0, 4'h0, 1'b1, 16'h0B48, 1'b1}) begin
            n_fails++;
            $display("FAIL restart: got o=%h f=%h v=%b d=%h b=%b, expected 0 0 1 0b48 1",
                     popen0, pfail0, tvalid[0], tdata[0], busy[0]);
        end
        serve(0, 1'b1, 5);
        for (int k = 0; k < 2; k++) begin
            serve(0, 1'b0, 5);
            restart[0] = 1'b1;
            n = 1;
            while (!tvalid[0] && n < 200) begin
                @(negedge clk);
                restart[0] = 1'b0;
                n++;
            end
            restart[0] = 1'b0;
            n_checks++;
            if ({32'(n), tdata[0]} !== {32'(RI + 1), 16'h0B49}) begin
                n_fails++;
                $display("FAIL retry_spacing[%0d]: got %0d cycles d=%h, expected %0d d=0b49", k, n, tdata[0], RI + 1);
            end
        end
        serve(0, 1'b1, 5);
        n_checks++;
        if ({popen0[1], pfail0[1]} !== 2'b10) begin
            n_fails++;
            $display("FAIL retry_result: got open1=%b fail1=%b, expected 1 0", popen0[1], pfail0[1]);
        end
        serve(0, 1'b1, 5);
        serve(0, 1'b1, 5);
        @(negedge clk);
        for (int j = 0; j < 6; j++) if (hs_data[0][j] == 16'h0B49) cnt49++;
        n_checks++;
        if ({32'(hs_cnt[0]), 32'(cnt49)} !== {32'd6, 32'd3}) begin
            n_fails++;
            $display("FAIL retry_requests: got hs=%0d n0b49=%0d, expected 6 3", hs_cnt[0], cnt49);
        end
        n_checks++;
        if ({popen0, pfail0, done[0]} !== {4'hF, 4'h0, 1'b1}) begin
            n_fails++;
            $display("FAIL retry_masks: got o=%h f=%h done=%b, expected f 0 1", popen0, pfail0, done[0]);
        end
    endtask

    task automatic test_reset_midop;
        int n = 0;
        restart[0] = 1'b1;
        @(negedge clk);
        restart[0] = 1'b0;
        serve(0, 1'b1, 5);
        serve(0, 1'b1, 5);
        while (!tvalid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tdata[0] !== 16'h0B4A) begin
            n_fails++;
            $display("FAIL midop_port2: got %h, expected 0b4a", tdata[0]);
        end
        repeat (4) @(negedge clk);
        rstn[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tvalid[0], tdata[0], popen0, pfail0, busy[0], done[0]} !==
            {1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL midop_reset: got v=%b d=%h o=%h f=%h b=%b dn=%b, expected 0 0000 0 0 1 0",
                     tvalid[0], tdata[0], popen0, pfail0, busy[0], done[0]);
        end
        rstn[0]   = 1'b1;
        sdata[0]  = 8'h01;
        svalid[0] = 1'b1;
        n = 0;
        while (!tvalid[0] && n < 200) begin
            @(negedge clk);
            svalid[0] = 1'b0;
            sdata[0]  = 8'h00;
            n++;
        end
        n_checks++;
        if ({32'(n), tdata[0], popen0} !== {32'(SD + 1), 16'h0B48, 4'h0}) begin
            n_fails++;
            $display("FAIL midop_restart: got %0d cycles d=%h o=%h, expected %0d 0b48 0", n, tdata[0], popen0, SD + 1);
        end
        rstn[0] = 1'b0;
    endtask

    task automatic test_timeout;
        int n = 0;
        int cnt4a = 0;
        hs_cnt[1] = 0;
        rstn[1]   = 1'b1;
        serve(1, 1'b1, 5);
        serve(1, 1'b1, 5);
        while (!tvalid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n = 1;
        while (!tvalid[1] && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({32'(n), tdata[1]} !== {32'(TO + RI + 1), 16'h0B4A}) begin
            n_fails++;
            $display("FAIL timeout_retry: got %0d cycles d=%h, expected %0d 0b4a", n, tdata[1], TO + RI + 1);
        end
        @(negedge clk);
        n = 1;
        while (!tvalid[1] && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({32'(n), tdata[1], pfail1} !== {32'(TO + 2), 16'h0B4B, 4'b0100}) begin
            n_fails++;
            $display("FAIL timeout_giveup: got %0d cycles d=%h f=%b, expected %0d 0b4b 0100", n, tdata[1], pfail1, TO + 2);
        end
        serve(1, 1'b1, 5);
        @(negedge clk);
        for (int j = 0; j < 5; j++) if (hs_data[1][j] == 16'h0B4A) cnt4a++;
        n_checks++;
        if ({popen1, pfail1, done[1], 32'(cnt4a)} !== {4'b1011, 4'b0100, 1'b1, 32'd2}) begin
            n_fails++;
            $display("FAIL timeout_masks: got o=%b f=%b done=%b n0b4a=%0d, expected 1011 0100 1 2",
                     popen1, pfail1, done[1], cnt4a);
        end
    endtask

    task automatic test_beat_at_timeout;
        restart[1] = 1'b1;
        @(negedge clk);
        restart[1] = 1'b0;
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        sdata[1]  = 8'h01;
        svalid[1] = 1'b1;
        @(negedge clk);
        svalid[1] = 1'b0;
        sdata[1]  = 8'h00;
        n_checks++;
        if ({popen1, pfail1} !== {4'b0001, 4'b0000}) begin
            n_fails++;
            $display("FAIL tie_masks: got o=%b f=%b, expected 0001 0000", popen1, pfail1);
        end
        @(negedge clk);
        n_checks++;
        if ({tvalid[1], tdata[1]} !== {1'b1, 16'h0B49}) begin
            n_fails++;
            $display("FAIL tie_next: got v=%b d=%h, expected v=1 d=0b49", tvalid[1], tdata[1]);
        end
        rstn[1] = 1'b0;
    endtask

    task automatic test_wrap;
        hs_cnt[2] = 0;
        rstn[2]   = 1'b1;
        serve(2, 1'b1, 5);
        serve(2, 1'b1, 5);
        @(negedge clk);
        n_checks++;
        if ({32'(hs_cnt[2]), hs_data[2][0], hs_data[2][1]} !== {32'd2, 16'hFFFF, 16'h0000}) begin
            n_fails++;
            $display("FAIL wrap_tdata: got hs=%0d %h %h, expected 2 ffff 0000", hs_cnt[2], hs_data[2][0], hs_data[2][1]);
        end
        n_checks++;
        if ({popen2, pfail2, done[2]} !== {2'b11, 2'b00, 1'b1}) begin
            n_fails++;
            $display("FAIL wrap_masks: got o=%b f=%b done=%b, expected 11 00 1", popen2, pfail2, done[2]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d]    = 1'b0;
            tready[d]  = 1'b1;
            svalid[d]  = 1'b0;
            sdata[d]   = 8'h00;
            restart[d] = 1'b0;
            hs_cnt[d]  = 0;
        end
        test_reset;
        test_backpressure;
        test_main;
        test_restart_retry;
        test_reset_midop;
        test_timeout;
        test_beat_at_timeout;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
